// File: rtl/gate_model_bist_if.sv
// Bus between the practicum control logic / gate model and the BIST sequencer.
// The master side is the environment: it issues start/abort and returns the
// gate-model outputs. The slave side is the sequencer, which drives the
// stimulus vector and reports status.
interface gate_model_bist_if #(
  parameter int IN_W  = 21,
  parameter int OUT_W = 10
);
  logic              start;
  logic              abort;
  logic [IN_W-1:0]   dut_in;
  logic [OUT_W-1:0]  dut_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [OUT_W-1:0]  signature;
  logic [15:0]       vec_count;

  modport master (
    output start, abort, dut_out,
    input  dut_in, busy, done, pass, signature, vec_count
  );

  modport slave (
    input  start, abort, dut_out,
    output dut_in, busy, done, pass, signature, vec_count
  );
endinterface

// File: rtl/gate_model_bist_ctrl.sv
// Self-test sequencer for a 21-input / 10-output combinational gate model.
// A 21-bit LFSR (x^21+x^19+1) generates input vectors; each vector is held
// SETTLE cycles and then captured into a 10-bit MISR (x^10+x^7+1). After
// NUM_VEC vectors the final signature is compared with EXP_SIG.
module gate_model_bist_ctrl #(
  parameter int              IN_W    = 21,
  parameter int              OUT_W   = 10,
  parameter int              SETTLE  = 2,
  parameter int              NUM_VEC = 1024,
  parameter logic [IN_W-1:0] SEED    = 21'h000001,
  parameter logic [OUT_W-1:0] EXP_SIG = 10'h000
) (
  input  logic              clk,
  input  logic              rst,
  gate_model_bist_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  // Counter reload value and the pre-increment count of the final vector.
  localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [15:0] LAST_VEC    = 16'(NUM_VEC - 1);

  state_t            state;
  logic [3:0]        settle_cnt;
  logic [IN_W-1:0]   dut_in_q;
  logic [OUT_W-1:0]  sig_q;
  logic [15:0]       vec_count_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;

  logic [IN_W-1:0]   lfsr_next;
  logic [OUT_W-1:0]  misr_next;

  // Next LFSR vector: shift left, feedback from taps 21 and 19.
  assign lfsr_next = {dut_in_q[IN_W-2:0], dut_in_q[20] ^ dut_in_q[18]};

  // Next MISR value: shift left with taps 10 and 7, then fold in the model outputs.
  assign misr_next = {sig_q[OUT_W-2:0], sig_q[9] ^ sig_q[6]} ^ bus.dut_out;

  // Sequencer FSM; every output is a register so the gate model sees clean edges.
  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values; a blocking '=' would let misr_next/lfsr_next see half-updated state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      settle_cnt  <= '0;
      dut_in_q    <= '0;
      sig_q       <= '0;
      vec_count_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else if (bus.abort) begin
      // Abort: back to idle, but keep vector, signature and count for debug.
      state  <= ST_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            dut_in_q    <= SEED;
            sig_q       <= '0;
            vec_count_q <= '0;
            settle_cnt  <= SETTLE_LOAD;
            state       <= ST_SETTLE;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            state <= ST_CAPTURE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end

        ST_CAPTURE: begin
          sig_q       <= misr_next;
          vec_count_q <= vec_count_q + 16'd1;
          if (vec_count_q == LAST_VEC) begin
            // Last vector: dut_in stays on the final pattern while done is shown.
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (misr_next == EXP_SIG);
          end else begin
            dut_in_q   <= lfsr_next;
            settle_cnt <= SETTLE_LOAD;
            state      <= ST_SETTLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.dut_in    = dut_in_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = sig_q;
  assign bus.vec_count = vec_count_q;

endmodule

// File: tb/tb_gate_model_bist_ctrl.sv
// Bench for gate_model_bist_ctrl. Instance A: NUM_VEC=4, SETTLE=2, outputs
// tied low. Instances B/C: NUM_VEC=2, SETTLE=1, outputs tied high, differing
// only in EXP_SIG. Stimulus pushes expected responses into queues; monitor
// processes pop and compare when the DUT shows a new vector, a new capture
// or a rising done.
module tb_gate_model_bist_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gate_model_bist_if #(.IN_W(21), .OUT_W(10)) bus_a ();
  gate_model_bist_if #(.IN_W(21), .OUT_W(10)) bus_b ();
  gate_model_bist_if #(.IN_W(21), .OUT_W(10)) bus_c ();

  gate_model_bist_ctrl #(.NUM_VEC(4), .SETTLE(2), .EXP_SIG(10'h000)) u_a (
    .clk (clk), .rst (rst), .bus (bus_a.slave)
  );
  gate_model_bist_ctrl #(.NUM_VEC(2), .SETTLE(1), .EXP_SIG(10'h001)) u_b (
    .clk (clk), .rst (rst), .bus (bus_b.slave)
  );
  gate_model_bist_ctrl #(.NUM_VEC(2), .SETTLE(1), .EXP_SIG(10'h000)) u_c (
    .clk (clk), .rst (rst), .bus (bus_c.slave)
  );

  typedef struct {
    int          cyc;
    logic [9:0]  sig;
    logic [15:0] vc;
    logic        pass;
  } done_exp_t;

  done_exp_t   done_q_a[$];
  done_exp_t   done_q_b[$];
  done_exp_t   done_q_c[$];
  logic [20:0] din_q_a[$];
  logic [9:0]  sig_q_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected event, value %0h (cycle %0d)", name, act, cyc);
  endtask

  task automatic check_done(input string name, input done_exp_t e,
                            input logic [9:0] sig, input logic [15:0] vc, input logic pass);
    check({name, "_done_cycle"}, cyc, e.cyc);
    check({name, "_sig"}, sig, e.sig);
    check({name, "_vec_count"}, vc, e.vc);
    check({name, "_pass"}, pass, e.pass);
  endtask

  // Monitor A: each new nonzero dut_in must be the next queued vector and,
  // within a run, the previous one must have been held SETTLE+1 = 3 cycles.
  logic [20:0] din_prev_a   = '0;
  int          din_chg_a    = 0;
  logic        done_prev_a  = 1'b0;
  always @(negedge clk) begin
    logic [20:0] e;
    done_exp_t   d;
    if (!rst && bus_a.dut_in !== din_prev_a && bus_a.dut_in != 21'd0) begin
      if (din_q_a.size() == 0) begin
        unexpected("a_dut_in_extra", bus_a.dut_in);
      end else begin
        e = din_q_a.pop_front();
        check("a_dut_in", bus_a.dut_in, e);
        if (e != 21'h000001) check("a_hold_cycles", cyc - din_chg_a, 3);
      end
      din_chg_a = cyc;
    end
    din_prev_a = bus_a.dut_in;
    if (bus_a.done && !done_prev_a) begin
      if (done_q_a.size() == 0) unexpected("a_done_extra", bus_a.vec_count);
      else begin
        d = done_q_a.pop_front();
        check_done("a", d, bus_a.signature, bus_a.vec_count, bus_a.pass);
      end
    end
    done_prev_a = bus_a.done;
  end

  // Monitor B/C: per-capture signature on B, final results on both.
  logic [15:0] vc_prev_b   = '0;
  logic        done_prev_b = 1'b0;
  logic        done_prev_c = 1'b0;
  always @(negedge clk) begin
    done_exp_t d;
    if (!rst && bus_b.vec_count !== vc_prev_b && bus_b.vec_count != 16'd0) begin
      if (sig_q_b.size() == 0) unexpected("b_capture_extra", bus_b.signature);
      else check("b_capture_sig", bus_b.signature, sig_q_b.pop_front());
    end
    vc_prev_b = bus_b.vec_count;
    if (bus_b.done && !done_prev_b) begin
      if (done_q_b.size() == 0) unexpected("b_done_extra", bus_b.signature);
      else begin
        d = done_q_b.pop_front();
        check_done("b", d, bus_b.signature, bus_b.vec_count, bus_b.pass);
      end
    end
    done_prev_b = bus_b.done;
    if (bus_c.done && !done_prev_c) begin
      if (done_q_c.size() == 0) unexpected("c_done_extra", bus_c.signature);
      else begin
        d = done_q_c.pop_front();
        check_done("c", d, bus_c.signature, bus_c.vec_count, bus_c.pass);
      end
    end
    done_prev_c = bus_c.done;
  end

  // Expectations for a full run of instance A started at the next edge.
  task automatic expect_full_run_a();
    done_exp_t d;
    din_q_a.push_back(21'h000001);
    din_q_a.push_back(21'h000002);
    din_q_a.push_back(21'h000004);
    din_q_a.push_back(21'h000008);
    d.cyc = cyc + 1 + 12; d.sig = 10'h000; d.vc = 16'd4; d.pass = 1'b1;
    done_q_a.push_back(d);
  endtask

  // Expectations for a full run of instances B and C started at the next edge.
  task automatic expect_full_run_bc();
    done_exp_t d;
    sig_q_b.push_back(10'h3FF);
    sig_q_b.push_back(10'h001);
    d.cyc = cyc + 1 + 4; d.sig = 10'h001; d.vc = 16'd2; d.pass = 1'b1;
    done_q_b.push_back(d);
    d.pass = 1'b0;
    done_q_c.push_back(d);
  endtask

  task automatic pulse_start_a();
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
  endtask

  task automatic pulse_start_bc();
    bus_b.start = 1'b1;
    bus_c.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    bus_c.start = 1'b0;
  endtask

  function automatic logic done_sel(input int which);
    return (which == 0) ? bus_a.done : bus_b.done;
  endfunction

  task automatic wait_done(input int which, input int budget);
    int n = 0;
    while (!done_sel(which) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) unexpected("done_timeout", which);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.dut_out = 10'h000;
    bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.dut_out = 10'h3FF;
    bus_c.start = 1'b0; bus_c.abort = 1'b0; bus_c.dut_out = 10'h3FF;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_dut_in", bus_a.dut_in, 0);
    check("rst_signature", bus_a.signature, 0);
    check("rst_vec_count", bus_a.vec_count, 0);
    check("rst_busy", bus_a.busy, 0);
    check("rst_done", bus_a.done, 0);
    check("rst_pass", bus_a.pass, 0);
    rst = 1'b0;
    @(negedge clk);

    // Run 1 on A: LFSR sequence 1,2,4,8; done 12 cycles after start.
    expect_full_run_a();
    pulse_start_a();
    check("a_busy_after_start", bus_a.busy, 1);
    check("a_pass_while_busy", bus_a.pass, 0);
    wait_done(0, 40);
    repeat (2) @(negedge clk);
    check("a_done_held", bus_a.done, 1);
    check("a_frozen_dut_in", bus_a.dut_in, 21'h000008);
    check("a_frozen_vec_count", bus_a.vec_count, 4);

    // Restart from DONE clears done and signature at the start edge.
    expect_full_run_a();
    pulse_start_a();
    check("a_restart_done", bus_a.done, 0);
    check("a_restart_vec_count", bus_a.vec_count, 0);
    wait_done(0, 40);
    @(negedge clk);

    // Start while busy during vector 2 must be ignored.
    expect_full_run_a();
    pulse_start_a();
    repeat (3) @(negedge clk);
    pulse_start_a();
    check("a_busy_start_vec_count", bus_a.vec_count, 1);
    wait_done(0, 40);
    @(negedge clk);

    // Abort together with start, landing just after the third capture.
    din_q_a.push_back(21'h000001);
    din_q_a.push_back(21'h000002);
    din_q_a.push_back(21'h000004);
    din_q_a.push_back(21'h000008);
    pulse_start_a();
    repeat (9) @(negedge clk);
    bus_a.abort = 1'b1;
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.abort = 1'b0;
    bus_a.start = 1'b0;
    check("abort_busy", bus_a.busy, 0);
    check("abort_done", bus_a.done, 0);
    check("abort_vec_count", bus_a.vec_count, 3);
    check("abort_dut_in", bus_a.dut_in, 21'h000008);
    repeat (2) @(negedge clk);
    check("abort_stays_idle", bus_a.busy, 0);
    expect_full_run_a();
    pulse_start_a();
    wait_done(0, 40);
    @(negedge clk);

    // MISR arithmetic on B/C, then a restart that must reproduce it.
    expect_full_run_bc();
    pulse_start_bc();
    wait_done(1, 20);
    @(negedge clk);
    expect_full_run_bc();
    pulse_start_bc();
    check("b_restart_done", bus_b.done, 0);
    check("b_restart_sig", bus_b.signature, 0);
    wait_done(1, 20);
    @(negedge clk);

    // Reset mid-SETTLE: outputs clear before the next clock edge, no done.
    din_q_a.push_back(21'h000001);
    pulse_start_a();
    #2 rst = 1'b1;
    #1;
    check("midrst_dut_in", bus_a.dut_in, 0);
    check("midrst_busy", bus_a.busy, 0);
    check("midrst_done", bus_a.done, 0);
    check("midrst_b_done", bus_b.done, 0);
    check("midrst_b_sig", bus_b.signature, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_no_done", bus_a.done, 0);

    check("left_din_a", din_q_a.size(), 0);
    check("left_done_a", done_q_a.size(), 0);
    check("left_done_b", done_q_b.size(), 0);
    check("left_done_c", done_q_c.size(), 0);
    check("left_sig_b", sig_q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
